// File: rtl/mv_row_sched_if.sv
`default_nettype none
// ==== mv_row_sched_if : start/done, controller and result-buffer signals of mv_row_sched -- rev 1.0 ====
interface mv_row_sched_if #(
  parameter int L_RAM_SIZE = 6,
  parameter int MEM_AW     = 10,
  parameter int RES_AW     = 4
);
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  con_start;
  logic                  con_done;
  logic [L_RAM_SIZE-1:0] con_rdaddr;
  logic [31:0]           con_wrdata;
  logic [MEM_AW-1:0]     mem_rdaddr;
  logic                  res_we;
  logic [RES_AW-1:0]     res_addr;
  logic [31:0]           res_wrdata;
`ifdef MV_ROW_SCHED_PERF_EN
  logic [31:0]           perf_cycles;
`endif

  modport master (
    input  start, abort, con_done, con_rdaddr, con_wrdata,
    output busy, done, con_start, mem_rdaddr, res_we, res_addr, res_wrdata
`ifdef MV_ROW_SCHED_PERF_EN
    , output perf_cycles
`endif
  );

  modport slave (
    output start, abort, con_done, con_rdaddr, con_wrdata,
    input  busy, done, con_start, mem_rdaddr, res_we, res_addr, res_wrdata
`ifdef MV_ROW_SCHED_PERF_EN
    , input perf_cycles
`endif
  );
endinterface
`default_nettype wire

// File: rtl/mv_row_sched.sv
`default_nettype none
// ==== mv_row_sched : one dot-product job per matrix row, result stored at index=row -- rev 1.0 ====
// Optional macro MV_ROW_SCHED_PERF_EN adds the perf_cycles run-length counter.
module mv_row_sched #(
  parameter int N_ROWS     = 16,
  parameter int L_RAM_SIZE = 6,
  parameter int MEM_AW     = 10,
  parameter int ROW_STRIDE = 64,
  parameter int RES_AW     = 4
) (
  input  logic           aclk,
  input  logic           areset,
  mv_row_sched_if.master bus
);
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CNT_W = (ROW_W > RES_AW) ? ROW_W : RES_AW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [CNT_W-1:0]  c_last_row = CNT_W'(N_ROWS - 1);
  localparam logic [MEM_AW-1:0] c_stride   = MEM_AW'(ROW_STRIDE);

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [CNT_W-1:0]      r_row;
  logic [MEM_AW-1:0]     r_base;
  logic [31:0]           r_result;
  logic                  r_con_done_q;
  logic [L_RAM_SIZE-1:0] w_rdaddr;
  logic                  w_rise;
  logic                  w_last;

  assign w_rdaddr       = bus.con_rdaddr;
  assign w_rise         = bus.con_done & ~r_con_done_q;
  assign w_last         = (r_row == c_last_row);
  assign bus.mem_rdaddr = r_base + MEM_AW'(w_rdaddr);

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_rise) w_next = S_WRITE;
      S_WRITE: w_next = S_DRAIN;
      S_DRAIN: if (!bus.con_done) w_next = w_last ? S_FIN : S_ISSUE;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // abort overrides every other transition
    if (bus.abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_comb begin
    bus.busy       = (r_state != S_IDLE);
    bus.con_start  = (r_state == S_ISSUE);
    bus.res_we     = (r_state == S_WRITE) && !bus.abort;
    bus.done       = (r_state == S_FIN) && !bus.abort;
    bus.res_addr   = r_row[RES_AW-1:0];
    bus.res_wrdata = r_result;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_row        <= '0;
      r_base       <= '0;
      r_result     <= '0;
      r_con_done_q <= 1'b0;
    end else begin
      r_con_done_q <= bus.con_done;
      if ((r_state == S_IDLE) && bus.start) begin
        r_row  <= '0;
        r_base <= '0;
      end else if (!bus.abort) begin
        if ((r_state == S_WAIT) && w_rise) r_result <= bus.con_wrdata;
        if ((r_state == S_DRAIN) && !bus.con_done && !w_last) begin
          r_row  <= r_row + 1'b1;
          r_base <= r_base + c_stride;
        end
      end
    end
  end

`ifdef MV_ROW_SCHED_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge aclk) begin
    if (areset)                                r_perf <= '0;
    else if ((r_state == S_IDLE) && bus.start) r_perf <= '0;
    else if ((r_state != S_IDLE) && !bus.abort && (r_perf != 32'hFFFF_FFFF))
      r_perf <= r_perf + 32'd1;
  end

  assign bus.perf_cycles = r_perf;
`endif
endmodule
`default_nettype wire

// File: doc/mv_row_sched.md
Name: mv_row_sched

Overview:
- Sequences a matrix-vector multiply over the single dot-product controller.
- Issues one dot-product job per matrix row and relocates the controller's local read address into the row's region of shared BRAM.
- Captures each scalar result and writes it into a result buffer at index = row number.
- Sits between the top-level start/done interface and one dot-product controller instance.

Parameters:
- N_ROWS, 16, number of rows processed per run (>=1)
- L_RAM_SIZE, 6, width of the controller-side read address
- MEM_AW, 10, width of the shared BRAM address
- ROW_STRIDE, 64, BRAM words between consecutive row bases
- RES_AW, 4, result buffer address width; 2**RES_AW >= N_ROWS

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- start  in  1  start a run; sampled only in S_IDLE
- abort  in  1  abandon the current run
- busy  out  1  high in every state except S_IDLE
- done  out  1  one-cycle pulse when the last result is written
- con_start  out  1  one-cycle start pulse to the controller
- con_done  in  1  controller done (level, held several cycles)
- con_rdaddr  in  L_RAM_SIZE  controller local read address
- con_wrdata  in  32  controller result
- mem_rdaddr  out  MEM_AW  base + zero-extended con_rdaddr, modulo 2**MEM_AW
- res_we  out  1  result buffer write enable
- res_addr  out  RES_AW  result index
- res_wrdata  out  32  result value

Behaviour:
- Reset: all outputs 0; state S_IDLE; row, base, captured result and con_done_q all 0.
- Reset mid-run: discards everything and returns to S_IDLE next cycle; no done pulse, no write.
- con_done_q is con_done registered. A rising edge is con_done & !con_done_q.
- mem_rdaddr is combinational: base + con_rdaddr. No latency.
- S_IDLE: start=1 -> S_ISSUE, with row<=0 and base<=0. Otherwise stay.
- S_ISSUE: con_start=1 for exactly this cycle -> S_WAIT.
- S_WAIT: on a con_done rising edge, latch con_wrdata -> S_WRITE.
  - A con_done already high on entry (no rising edge) is ignored.
- S_WRITE: for one cycle res_we=1, res_addr=row[RES_AW-1:0], res_wrdata=latched value -> S_DRAIN.
- S_DRAIN: wait for con_done==0, so the controller is back in idle.
  - If row==N_ROWS-1 -> S_FIN.
  - Else row<=row+1, base<=base+ROW_STRIDE (wraps modulo 2**MEM_AW) -> S_ISSUE.
- S_FIN: done=1 for one cycle -> S_IDLE.
- res_we, con_start and done are registered-state decodes only; each is high at most one cycle per event.
- start while busy is ignored; it is not queued.
- abort=1 in any non-idle state -> S_IDLE next cycle.
  - Suppresses any res_we/done that would have issued that cycle; abort wins over all other transitions.
  - Counters are not cleared until the next start.
  - abort in S_IDLE has no effect.
- N_ROWS=1: one ISSUE/WAIT/WRITE/DRAIN pass, then S_FIN.
- Results are written in strictly ascending row order, one per row. No row is skipped or duplicated.

Optional Feature:
- Macro: MV_ROW_SCHED_PERF_EN.
- Defined:
  - Adds output perf_cycles [31:0], counting aclk cycles from the S_IDLE->S_ISSUE transition through S_FIN inclusive.
  - Holds its value in S_IDLE until the next start; cleared by areset and at the start of each run.
  - Saturates at 32'hFFFFFFFF.
  - Abort freezes it at its current value.
- Not defined: the port does not exist; the counter logic is absent.

Test Plan:
- Reset then idle: areset 2 cycles, start=0 -> all outputs 0, busy=0 for 20 cycles.
- Full run: N_ROWS=4, ROW_STRIDE=64, controller model asserts con_done for 5 cycles, 50 cycles after each con_start, returning 32'h10+row -> writes (0,32'h10),(1,32'h11),(2,32'h12),(3,32'h13) in order; con_start pulses exactly 4 times; done pulses once, one cycle after the DRAIN of row 3.
- Address relocation: con_rdaddr=6'd5 during row 2 -> mem_rdaddr=133. With MEM_AW=7 and row 2 -> mem_rdaddr=5 (wrap).
- Stuck done / double start: con_done held high on entry to S_WAIT -> no capture until it falls and rises again. start pulsed in S_WAIT -> ignored, row unchanged.
- Abort and reset mid-run: abort in S_WAIT of row 1 -> busy=0 next cycle, no res_we, no done. Next start restarts at row 0, base 0. Same scenario with areset instead of abort gives the same response.
- Perf (macro defined): the run from the full-run scenario yields a fixed, repeatable perf_cycles; a second identical run gives the same value; an aborted run freezes the count.
